// File: rtl/cbd_timer_ctrl.sv
// -----------------------------------------------------------------------------
// cbd_timer_ctrl
//
// Control stage for a cascade of 4-bit down counters with CAI/CAO. It prescales
// clk_i into single-cycle count ticks, drives the chain's load/enable controls,
// and watches the last stage's carry-out (tc_i) for expiry. On expiry it either
// stops (one-shot) or reloads the chain (periodic), and raises a registered
// expiry pulse plus sticky pending/overrun flags for a host.
//
// Ports:
//   clk_i    rising-edge clock
//   cd_i     asynchronous clear, active-high
//   start_i  begin or retrigger a timing run (level, sampled each edge)
//   stop_i   abort the run (level, sampled each edge)
//   mode_i   0 = one-shot, 1 = periodic auto-reload (sampled at expiry)
//   pre_i    prescale value, captured only in the load cycle
//   ack_i    clears pend_o and ovr_o
//   tc_i     carry-out of the last chain stage
//   ld_o     parallel-load strobe to every chain stage
//   en_o     count enable to every chain stage
//   cai_o    carry-in tick to the first chain stage
//   busy_o   high while loading or running
//   irq_o    one-cycle expiry pulse
//   pend_o   sticky expiry flag
//   ovr_o    sticky overrun flag (expiry while pend_o already set)
// -----------------------------------------------------------------------------
module cbd_timer_ctrl #(
   parameter int unsigned PW = 8
) (
   input  logic          clk_i,
   input  logic          cd_i,
   input  logic          start_i,
   input  logic          stop_i,
   input  logic          mode_i,
   input  logic [PW-1:0] pre_i,
   input  logic          ack_i,
   input  logic          tc_i,
   output logic          ld_o,
   output logic          en_o,
   output logic          cai_o,
   output logic          busy_o,
   output logic          irq_o,
   output logic          pend_o,
   output logic          ovr_o
);

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StLoad = 2'd1,
      StRun  = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic [PW-1:0] pcnt_q, pcnt_d;
   logic [PW-1:0] pre_q, pre_d;
   logic          irq_q, irq_d;
   logic          pend_q, pend_d;
   logic          ovr_q, ovr_d;
   logic          expiry;

   // Outputs decode straight from registers so a clear drops them immediately.
   assign ld_o   = (state_q == StLoad);
   assign en_o   = (state_q == StRun);
   assign cai_o  = en_o && (pcnt_q == '0);
   assign busy_o = ld_o | en_o;
   assign irq_o  = irq_q;
   assign pend_o = pend_q;
   assign ovr_o  = ovr_q;

   // tc_i only means anything on a tick while running.
   assign expiry = en_o && cai_o && tc_i;

   always_comb begin
      state_d = state_q;
      pcnt_d  = pcnt_q;
      pre_d   = pre_q;
      unique case (state_q)
         StIdle: begin
            if (start_i && !stop_i) state_d = StLoad;
         end
         StLoad: begin
            pre_d   = pre_i;
            pcnt_d  = pre_i;
            state_d = stop_i ? StIdle : StRun;
         end
         StRun: begin
            // Wrap only by reload from the captured prescale; never underflow.
            pcnt_d = (pcnt_q == '0) ? pre_q : pcnt_q - PW'(1);
            if (stop_i)       state_d = StIdle;
            else if (start_i) state_d = StLoad;
            else if (expiry)  state_d = mode_i ? StLoad : StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Expiry is reported even when stop/start wins the next-state decision,
   // and a coincident expiry beats ack.
   assign irq_d  = expiry;
   assign pend_d = expiry | (pend_q & ~ack_i);
   assign ovr_d  = (expiry & pend_q & ~ack_i) | (ovr_q & ~ack_i);

   always_ff @(posedge clk_i or posedge cd_i) begin
      if (cd_i) begin
         state_q <= StIdle;
         pcnt_q  <= '0;
         pre_q   <= '0;
         irq_q   <= 1'b0;
         pend_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pcnt_q  <= pcnt_d;
         pre_q   <= pre_d;
         irq_q   <= irq_d;
         pend_q  <= pend_d;
         ovr_q   <= ovr_d;
      end
   end

endmodule

// File: doc/cbd_timer_ctrl.md
Name: cbd_timer_ctrl

Overview:
Control stage that sits directly upstream of a cascade of 4-bit down counters with CAI/CAO, and also consumes their terminal count. It prescales CLK into single-cycle CAI count ticks and issues the LD/EN controls to the chain. It takes the last stage's CAO back as TC and, on expiry, either stops (one-shot) or reloads (periodic). It raises an expiry pulse plus sticky pending/overrun flags for a host.

Parameters:
PW, 8, prescaler width; the tick period is PRE+1 CLK cycles, PRE in 0..2^PW-1.

Ports:
CLK  in  1  clock, rising edge.
CD  in  1  asynchronous clear, active-high.
START  in  1  level, sampled each edge; begin or retrigger a timing run.
STOP  in  1  level, sampled each edge; abort the run.
MODE  in  1  0 = one-shot, 1 = periodic auto-reload; sampled at TC.
PRE  in  PW  prescale value; latched in LOAD only.
ACK  in  1  clears PEND and OVR.
TC  in  1  CAO of the last chain stage (chain value 0 while CAI&EN).
LD  out  1  parallel-load strobe to every chain stage.
EN  out  1  count enable to every chain stage.
CAI  out  1  carry-in tick to the first chain stage.
BUSY  out  1  high in LOAD or RUN.
IRQ  out  1  one-cycle expiry pulse, registered.
PEND  out  1  sticky expiry flag.
OVR  out  1  sticky overrun flag: expiry while PEND is already set.

Behaviour:
- Reset (CD=1, async): state=IDLE, pcnt=0, pre_r=0, IRQ=PEND=OVR=0. All outputs read 0.
- States: IDLE, LOAD, RUN. LD = (state==LOAD). EN = (state==RUN). BUSY = LD|EN. CAI = EN && (pcnt==0), combinational from registers only.
- IDLE: if START && !STOP, go to LOAD; otherwise stay.
- LOAD (exactly 1 cycle): pre_r<=PRE, pcnt<=PRE. If STOP, go to IDLE; otherwise go to RUN.
- RUN: pcnt <= (pcnt==0) ? pre_r : pcnt-1. CAI therefore fires in RUN cycles PRE+1, 2(PRE+1), and so on; PRE=0 gives CAI every RUN cycle.
- Expiry event E = (state==RUN) && CAI && TC. TC is ignored whenever CAI=0 or state!=RUN.
- RUN next-state priority:
  1. STOP: go to IDLE.
  2. START: go to LOAD (retrigger).
  3. E: go to LOAD if MODE=1, or IDLE if MODE=0.
  4. Otherwise stay in RUN.
- E is still reported when STOP or START coincides with it.
- IRQ <= E, so it is high for one cycle, in the cycle after the TC edge.
- PEND <= E | (PEND & ~ACK). E wins over a simultaneous ACK.
- OVR <= (E & PEND & ~ACK) | (OVR & ~ACK).
- Chain loaded with value V expires on tick V+1, so the period is (V+1)(PRE+1) RUN cycles. Periodic mode adds one LOAD cycle per period.
- PRE changes outside LOAD have no effect until the next LOAD.
- CD mid-run: immediate return to IDLE; LD/EN/CAI drop asynchronously and the flags clear.
- pcnt wraps only via reload from pre_r and never underflows.

Test Plan:
1. Reset, then START pulse, PRE=2, MODE=0, chain D=3: LD high for 1 cycle; CAI in RUN cycles 3, 6, 9, 12; TC on the 4th tick; IRQ=1 the next cycle; then IDLE, BUSY=0, PEND=1.
2. MODE=1, PRE=0, D=1: CAI every RUN cycle; TC on the 2nd tick; LOAD, RUN repeats with an IRQ every 3 cycles. The second IRQ without ACK sets OVR=1. ACK clears PEND and OVR.
3. STOP asserted in RUN cycle 2 (PRE=4): IDLE next cycle, no CAI ever, IRQ=0. START and STOP together in IDLE: stays IDLE.
4. START re-asserted mid-run (PRE=3): LOAD next cycle, pcnt reloads, and the next CAI arrives 4 cycles into the new RUN.
5. ACK in the same cycle as E with PEND=1: PEND stays 1, OVR stays 0. Separately, TC driven high while CAI=0: no IRQ, no state change.
6. CD pulse asynchronously mid-RUN: LD/EN/CAI/BUSY/PEND go to 0 before the next edge; state is IDLE after release.
